// File: rtl/rom_port_arbiter_if.sv
// Two-requester read bus into the ROM port arbiter. Each requester has a
// req/addr/gnt request side and an rvalid/rdata/err/rready response side.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_err_o;
    logic              m0_rready_i;

    logic              m1_req_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_err_o;
    logic              m1_rready_i;

    // Requester side (fetch unit, LSU, or a bench)
    modport master (
        output m0_req_i, m0_addr_i, m0_rready_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_addr_i, m1_rready_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o
    );

    // Arbiter side
    modport slave (
        input  m0_req_i, m0_addr_i, m0_rready_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_addr_i, m1_rready_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction-ROM read port between the fetch unit
// (m0) and the LSU (m1). One-entry response buffer, latency 1, back-to-back
// throughput of one read per cycle. Misaligned / out-of-range reads return
// err with zero data. Saturating counters for accepted reads and conflicts.
module rom_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4096,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    rom_port_arbiter_if.slave bus,
    output logic              rom_rena_o,
    output logic [ADDR_W-1:0] rom_raddr_o,
    input  logic [DATA_W-1:0] rom_rdata_i,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);
    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

    state_t            state, state_n;
    logic              owner;      // 0: m0 holds the buffer, 1: m1
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              prio_m1;    // round-robin pointer, 1 = m1 wins a tie
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  conflict_cnt;

    logic              done;       // owner consumes the buffered word this cycle
    logic              buf_free;
    logic              gnt0, gnt1;
    logic              accept;
    logic              win_m1;
    logic [ADDR_W-1:0] win_addr;
    logic              win_err;

    // Word index compared zero-extended so DEPTH is checked at full width.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= DEPTH_L);
    endfunction

    // Buffer status and grant decision; gnt never fires during reset.
    always_comb begin
        done     = 1'b0;
        buf_free = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (state == ST_RESP)
            done = owner ? bus.m1_rready_i : bus.m0_rready_i;
        buf_free = (state == ST_IDLE) || done;
        if (!rst && buf_free) begin
            if (bus.m0_req_i && bus.m1_req_i) begin
                if (ARB_MODE == 1 || !prio_m1) gnt0 = 1'b1;
                else                           gnt1 = 1'b1;
            end else begin
                gnt0 = bus.m0_req_i;
                gnt1 = bus.m1_req_i;
            end
        end
    end

    assign accept   = gnt0 | gnt1;
    assign win_m1   = gnt1;
    assign win_addr = win_m1 ? bus.m1_addr_i : bus.m0_addr_i;
    assign win_err  = addr_err(win_addr);

    assign bus.m0_gnt_o = gnt0;
    assign bus.m1_gnt_o = gnt1;
    assign rom_rena_o   = accept;
    assign rom_raddr_o  = accept ? win_addr : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state: a same-cycle accept keeps the buffer full with new data.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_RESP;
            ST_RESP: begin
                if (accept)    state_n = ST_RESP;
                else if (done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Response buffer and round-robin pointer update on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            prio_m1 <= 1'b0;
        end else if (accept) begin
            owner   <= win_m1;
            rdata_q <= win_err ? '0 : rom_rdata_i;
            err_q   <= win_err;
            prio_m1 <= ~win_m1;
        end
    end

    // Saturating performance counters; busy-buffer stalls are not conflicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (accept && rd_cnt != '1)
                rd_cnt <= rd_cnt + CNT_W'(1);
            if (bus.m0_req_i && bus.m1_req_i && buf_free && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign rd_cnt_o       = rd_cnt;
    assign conflict_cnt_o = conflict_cnt;

    // Only the owner sees the buffered response; the other side reads zeros.
    always_comb begin
        bus.m0_rvalid_o = 1'b0;
        bus.m0_rdata_o  = '0;
        bus.m0_err_o    = 1'b0;
        bus.m1_rvalid_o = 1'b0;
        bus.m1_rdata_o  = '0;
        bus.m1_err_o    = 1'b0;
        if (state == ST_RESP) begin
            if (owner) begin
                bus.m1_rvalid_o = 1'b1;
                bus.m1_rdata_o  = rdata_q;
                bus.m1_err_o    = err_q;
            end else begin
                bus.m0_rvalid_o = 1'b1;
                bus.m0_rdata_o  = rdata_q;
                bus.m0_err_o    = err_q;
            end
        end
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench: one round-robin instance (ua) and one fixed-priority
// instance (ub) sharing clock and reset, each with a small ROM model.
module tb_rom_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4096;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ia ();
    rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ib ();

    logic              rena_a, rena_b;
    logic [ADDR_W-1:0] raddr_a, raddr_b;
    logic [DATA_W-1:0] rom_a, rom_b;
    logic [CNT_W-1:0]  rdc_a, rdc_b, cfc_a, cfc_b;

    // ROM image: word 4 = DEADBEEF, otherwise 0x1000_0000 + word index.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = {2'b00, a[ADDR_W-1:2]};
        if (w == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + w;
    endfunction

    always_comb rom_a = rom_word(raddr_a);
    always_comb rom_b = rom_word(raddr_b);

    rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .ARB_MODE(0), .CNT_W(CNT_W)) ua (
        .clk(clk), .rst(rst), .bus(ia.slave),
        .rom_rena_o(rena_a), .rom_raddr_o(raddr_a), .rom_rdata_i(rom_a),
        .rd_cnt_o(rdc_a), .conflict_cnt_o(cfc_a));

    rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .ARB_MODE(1), .CNT_W(CNT_W)) ub (
        .clk(clk), .rst(rst), .bus(ib.slave),
        .rom_rena_o(rena_b), .rom_raddr_o(raddr_b), .rom_rdata_i(rom_b),
        .rd_cnt_o(rdc_b), .conflict_cnt_o(cfc_b));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [ADDR_W-1:0] err_addr [3];
    logic              err_exp  [3];
    logic [DATA_W-1:0] err_data [3];

    initial begin
        ia.m0_req_i = 0; ia.m0_addr_i = '0; ia.m0_rready_i = 1;
        ia.m1_req_i = 0; ia.m1_addr_i = '0; ia.m1_rready_i = 1;
        ib.m0_req_i = 0; ib.m0_addr_i = '0; ib.m0_rready_i = 1;
        ib.m1_req_i = 0; ib.m1_addr_i = '0; ib.m1_rready_i = 1;

        do_reset();
        #2;
        chk("rst_rvalid0", ia.m0_rvalid_o, 0);
        chk("rst_rvalid1", ia.m1_rvalid_o, 0);
        chk("rst_rdcnt",   rdc_a, 0);
        chk("rst_cfcnt",   cfc_a, 0);

        // Single fetch read of word 4
        ia.m0_req_i = 1; ia.m0_addr_i = 32'h10;
        #2;
        chk("t1_gnt",   ia.m0_gnt_o, 1);
        chk("t1_rena",  rena_a, 1);
        chk("t1_raddr", raddr_a, 32'h10);
        tick();
        ia.m0_req_i = 0;
        #2;
        chk("t1_rvalid", ia.m0_rvalid_o, 1);
        chk("t1_rdata",  ia.m0_rdata_o, 32'hDEAD_BEEF);
        chk("t1_err",    ia.m0_err_o, 0);
        chk("t1_m1v",    ia.m1_rvalid_o, 0);
        chk("t1_rdcnt",  rdc_a, 1);
        chk("t1_raddr0", raddr_a, 0);

        // Round-robin alternation with both requesting
        do_reset();
        ia.m0_req_i = 1; ia.m0_addr_i = 32'h20;
        ia.m1_req_i = 1; ia.m1_addr_i = 32'h40;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("t2_gnt0", ia.m0_gnt_o, (k % 2 == 0));
            chk("t2_gnt1", ia.m1_gnt_o, (k % 2 == 1));
            if (k > 0) begin
                chk("t2_v0", ia.m0_rvalid_o, (k % 2 == 1));
                chk("t2_v1", ia.m1_rvalid_o, (k % 2 == 0));
                chk("t2_d",  (k % 2 == 1) ? ia.m0_rdata_o : ia.m1_rdata_o,
                             (k % 2 == 1) ? 32'h1000_0008 : 32'h1000_0010);
            end
            tick();
        end
        ia.m0_req_i = 0; ia.m1_req_i = 0;
        #2;
        chk("t2_lastv1", ia.m1_rvalid_o, 1);
        chk("t2_lastv0", ia.m0_rvalid_o, 0);
        chk("t2_lastd",  ia.m1_rdata_o, 32'h1000_0010);
        chk("t2_cfcnt",  cfc_a, 4);
        chk("t2_rdcnt",  rdc_a, 4);
        tick();

        // Backpressure on m1 blocks m0
        ia.m1_rready_i = 0;
        ia.m1_req_i = 1; ia.m1_addr_i = 32'h44;
        #2;
        chk("t3_gnt1", ia.m1_gnt_o, 1);
        tick();
        ia.m1_req_i = 0;
        ia.m0_req_i = 1; ia.m0_addr_i = 32'h24;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t3_gnt0_hold", ia.m0_gnt_o, 0);
            chk("t3_v1_hold",   ia.m1_rvalid_o, 1);
            chk("t3_d1_hold",   ia.m1_rdata_o, 32'h1000_0011);
            tick();
        end
        ia.m1_rready_i = 1;
        #2;
        chk("t3_gnt0_rel", ia.m0_gnt_o, 1);
        chk("t3_v1_rel",   ia.m1_rvalid_o, 1);
        tick();
        ia.m0_req_i = 0;
        #2;
        chk("t3_v0",  ia.m0_rvalid_o, 1);
        chk("t3_d0",  ia.m0_rdata_o, 32'h1000_0009);
        chk("t3_v1",  ia.m1_rvalid_o, 0);
        chk("t3_cf",  cfc_a, 4);
        tick();

        // Error vectors
        err_addr[0] = 32'h2;           err_exp[0] = 1; err_data[0] = 32'h0;
        err_addr[1] = 32'h4000;        err_exp[1] = 1; err_data[1] = 32'h0;
        err_addr[2] = 32'h3FFC;        err_exp[2] = 0; err_data[2] = 32'h1000_0FFF;
        for (int k = 0; k < 3; k++) begin
            ia.m0_req_i = 1; ia.m0_addr_i = err_addr[k];
            #2;
            chk("t4_gnt",  ia.m0_gnt_o, 1);
            chk("t4_rena", rena_a, 1);
            tick();
            ia.m0_req_i = 0;
            #2;
            chk("t4_err",   ia.m0_err_o, err_exp[k]);
            chk("t4_rdata", ia.m0_rdata_o, err_data[k]);
            tick();
        end

        // Fixed priority instance: m1 starves
        ib.m0_req_i = 1; ib.m0_addr_i = 32'h10;
        ib.m1_req_i = 1; ib.m1_addr_i = 32'h40;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t5_gnt0", ib.m0_gnt_o, 1);
            chk("t5_gnt1", ib.m1_gnt_o, 0);
            tick();
        end
        ib.m0_req_i = 0; ib.m1_req_i = 0;
        #2;
        chk("t5_cfcnt", cfc_b, 5);
        chk("t5_rdcnt", rdc_b, 5);
        chk("t5_v1",    ib.m1_rvalid_o, 0);
        tick();

        // Reset while a response is pending
        ia.m0_rready_i = 0;
        ia.m0_req_i = 1; ia.m0_addr_i = 32'h10;
        tick();
        ia.m0_req_i = 0;
        #2;
        chk("t6_pend", ia.m0_rvalid_o, 1);
        rst = 1;
        ia.m0_req_i = 1; ia.m1_req_i = 1; ia.m1_addr_i = 32'h40;
        #2;
        chk("t6_rgnt0", ia.m0_gnt_o, 0);
        chk("t6_rgnt1", ia.m1_gnt_o, 0);
        chk("t6_rena",  rena_a, 0);
        tick();
        chk("t6_v0",    ia.m0_rvalid_o, 0);
        chk("t6_v1",    ia.m1_rvalid_o, 0);
        chk("t6_rdcnt", rdc_a, 0);
        chk("t6_cfcnt", cfc_a, 0);
        rst = 0;
        ia.m0_rready_i = 1;
        #2;
        chk("t6_gnt0", ia.m0_gnt_o, 1);
        chk("t6_gnt1", ia.m1_gnt_o, 0);
        ia.m0_req_i = 0; ia.m1_req_i = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational read port of the instruction ROM between two requesters.
  - m0: instruction fetch.
  - m1: load/store unit, for constant-pool reads.
- Arbitrates requests and drives the ROM address.
- Registers the returned word into a one-entry response buffer with valid/ready handshake.
- Flags misaligned and out-of-range accesses.
- Counts accepted reads and arbitration conflicts for performance monitoring.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, ROM word width.
- DEPTH, 4096, number of ROM words; word index = addr[ADDR_W-1:2].
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with m0 highest.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_req_i  in  1  fetch read request
- m0_addr_i  in  ADDR_W  fetch byte address
- m0_gnt_o  out  1  fetch request accepted this cycle
- m0_rvalid_o  out  1  fetch response valid
- m0_rdata_o  out  DATA_W  fetch response data
- m0_err_o  out  1  fetch response error; qualified by m0_rvalid_o
- m0_rready_i  in  1  fetch consumer ready
- m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o, m1_rready_i: same as m0, for the LSU
- rom_rena_o  out  1  ROM read enable
- rom_raddr_o  out  ADDR_W  ROM byte address
- rom_rdata_i  in  DATA_W  ROM combinational read data
- rd_cnt_o  out  CNT_W  accepted reads, saturating
- conflict_cnt_o  out  CNT_W  cycles in which both requests were high and one lost, saturating

Behaviour:
- Reset (rst high at a clk edge): all registered outputs and state clear at that edge.
  - rvalid, rdata, err, counters → 0.
  - Round-robin pointer → favours m0.
  - State → IDLE.
  - A pending response is discarded without being delivered.
- While rst is high: gnt outputs and rom_rena_o are forced to 0.
- States:
  - IDLE: response buffer empty.
  - RESP: buffer holds a word for owner (0/1).
- Buffer "free" means IDLE, or RESP with the owner's rready_i high this cycle.
- Grant (combinational): exactly one gnt, only when the buffer is free and at least one req is high.
  - ARB_MODE=1: m0 always wins.
  - ARB_MODE=0: if only one requester, it wins. If both, the one not granted last wins. The pointer updates only on an accepted grant.
- Accept = req & gnt in the same cycle.
  - rom_rena_o = 1.
  - rom_raddr_o = winner's address; it is 0 when there is no grant.
- Accept edge: response register captures rom_rdata_i, owner and err. State → RESP.
  - The owner's rvalid rises one cycle after accept, giving latency 1.
- Error:
  - err = addr[1:0] != 0, or addr[ADDR_W-1:2] >= DEPTH.
  - On error, rdata is captured as 0 and the ROM is still enabled.
- Response handshake: rvalid & rready completes the transfer.
  - Completion without a new accept → IDLE.
  - Completion with a same-cycle accept → stays RESP with the new data. Back-to-back throughput is 1 per cycle.
- Outputs stay stable while rvalid is high and rready is low.
  - rdata, err and owner held.
  - No new grant to either master.
- The non-owner's rvalid is always 0.
  - rdata is visible only to the owner; the non-owner's rdata and err are 0.
- Requester rules:
  - A requester may drop req before gnt.
  - Addr must be stable only in the accept cycle.
- rd_cnt_o increments by 1 per accept and saturates at all-ones.
- conflict_cnt_o increments in any cycle with both req high and the buffer free, and saturates.
  - Cycles blocked by a busy buffer are not counted.

Test Plan:
- Reset, then m0 reads addr 0x0000_0010 with ROM word 4 = 0xDEAD_BEEF and rready=1 → gnt same cycle; next cycle m0_rvalid=1, rdata=0xDEAD_BEEF, err=0; rd_cnt=1.
- ARB_MODE=0, both requesters hold req for 4 cycles with rready=1 → grant order m0,m1,m0,m1; conflict_cnt=4; each rvalid appears only on the owner's side.
- m1 reads, then m1_rready=0 for 3 cycles while m0_req=1 → m0_gnt=0, m1 rdata held for 3 cycles; m1_rready=1 in cycle 4 → m0 granted in that same cycle, m0_rvalid the next cycle.
- Errors: m0 addr 0x0000_0002 → err=1, rdata=0; m0 addr 4*DEPTH → err=1; addr 4*(DEPTH-1) → err=0.
- ARB_MODE=1, both requesters continuously requesting → m1 never granted; conflict_cnt counts every cycle.
- Assert rst while in RESP with rvalid high → next cycle rvalid=0, counters=0, gnt=0 during reset; first request after reset goes to m0 when both request.
